// File: rtl/spi_mem_loader_pkg.sv
// Shared definitions for the SPI parameter-memory loader.
//   MEM_WORDS / WORD_BITS : default memory depth and word/frame width
//   AW                    : address width for the default memory depth
//   state_e               : loader FSM state encoding
package spi_mem_loader_pkg;

  localparam int MEM_WORDS = 10;
  localparam int WORD_BITS = 8;
  localparam int AW        = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADDR    = 2'd1,
    DATA    = 2'd2,
    DISCARD = 2'd3
  } state_e;

endpackage

// File: rtl/spi_mem_loader_sync.sv
// Multi-flop synchronizer with rise/fall pulse detection in the clk domain.
//   clk, rst_n : system clock, async active-low reset
//   d          : asynchronous input
//   q          : synchronized level
//   rise, fall : one-clk pulses on synchronized transitions
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_mem_loader.sv
// SPI mode-0 slave that streams bytes into the weight/delay parameter memory.
// A transaction is one start-address byte followed by any number of data bytes,
// written to consecutive (wrapping) addresses.
//   clk, rst_n         : system clock (>= 4x sclk), async active-low reset
//   sclk, mosi, cs_n   : SPI slave inputs (asynchronous)
//   miso               : echo of the previously received byte, MSB first
//   data_out, addr_out : memory write data / address
//   write_enable       : one-clk memory write strobe
//   busy               : transaction in progress
//   load_done          : one-clk pulse after a transaction that wrote data
//   addr_err           : sticky, start address was out of range
module spi_mem_loader
  import spi_mem_loader_pkg::*;
#(
  parameter int M           = MEM_WORDS,
  parameter int N           = WORD_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 cs_n,
  output logic                 miso,
  output logic [N-1:0]         data_out,
  output logic [$clog2(M)-1:0] addr_out,
  output logic                 write_enable,
  output logic                 busy,
  output logic                 load_done,
  output logic                 addr_err
);

  localparam int PW = $clog2(M);
  localparam int CW = $clog2(N);

  logic sclk_s, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;
  logic cs_s, cs_rise_unused, cs_fall_unused;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi), .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );
  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_s), .rise(cs_rise_unused), .fall(cs_fall_unused)
  );

  state_e          state_q, state_d;
  logic [N-1:0]    rx_q, rx_d;
  logic [N-1:0]    tx_q, tx_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [N-1:0]    data_q, data_d;
  logic [PW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic            miso_q, miso_d;
  logic            wrote_q, wrote_d;
  logic            done_pend_q, done_pend_d;
  logic            load_done_q, load_done_d;
  logic            addr_err_q, addr_err_d;

  logic [N-1:0]    assembled;
  logic            last_bit;

  always_comb begin
    state_d     = state_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    bit_cnt_d   = bit_cnt_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    miso_d      = miso_q;
    wrote_d     = wrote_q;
    done_pend_d = 1'b0;
    load_done_d = 1'b0;
    addr_err_d  = addr_err_q;

    assembled = {rx_q[N-2:0], mosi_s};
    last_bit  = sclk_rise && (bit_cnt_q == CW'(N-1));

    // A write that coincided with cs_n rising reports done one cycle later,
    // so load_done never overlaps its own final strobe.
    if (done_pend_q) load_done_d = 1'b1;

    if (state_q == IDLE) begin
      miso_d    = 1'b0;
      tx_d      = '0;
      rx_d      = '0;
      bit_cnt_d = '0;
      if (!cs_s) begin
        state_d    = ADDR;
        addr_err_d = 1'b0;
        wrote_d    = 1'b0;
      end
    end else begin
      if (sclk_rise) begin
        rx_d      = assembled;
        bit_cnt_d = last_bit ? '0 : CW'(bit_cnt_q + 1'b1);
        if (last_bit) tx_d = assembled;
      end
      if (sclk_fall) begin
        miso_d = tx_q[N-1];
        tx_d   = {tx_q[N-2:0], 1'b0};
      end

      if (last_bit) begin
        case (state_q)
          ADDR: begin
            if (int'(assembled) < M) begin
              ptr_d   = assembled[PW-1:0];
              state_d = DATA;
            end else begin
              addr_err_d = 1'b1;
              state_d    = DISCARD;
            end
          end
          DATA: begin
            we_d    = 1'b1;
            data_d  = assembled;
            addr_d  = ptr_q;
            ptr_d   = (ptr_q == PW'(M-1)) ? '0 : PW'(ptr_q + 1'b1);
            wrote_d = 1'b1;
          end
          default: ;
        endcase
      end

      // Deselect drops any partial byte; a byte completing this cycle still writes.
      if (cs_s) begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        rx_d      = '0;
        if (we_d)         done_pend_d = 1'b1;
        else if (wrote_q) load_done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rx_q        <= '0;
      tx_q        <= '0;
      bit_cnt_q   <= '0;
      ptr_q       <= '0;
      data_q      <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      miso_q      <= 1'b0;
      wrote_q     <= 1'b0;
      done_pend_q <= 1'b0;
      load_done_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      bit_cnt_q   <= bit_cnt_d;
      ptr_q       <= ptr_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      miso_q      <= miso_d;
      wrote_q     <= wrote_d;
      done_pend_q <= done_pend_d;
      load_done_q <= load_done_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign miso         = miso_q;
  assign data_out     = data_q;
  assign addr_out     = addr_q;
  assign write_enable = we_q;
  assign busy         = (state_q != IDLE);
  assign load_done    = load_done_q;
  assign addr_err     = addr_err_q;

endmodule

// File: doc/spi_mem_loader.md
Name: spi_mem_loader

Overview:
- SPI-mode-0 slave that loads the synaptic weight/delay memory from the TinyTapeout pins.
- Sits directly upstream of the parameter memory and drives its data_in, addr and write_enable.
- Each transaction carries one start-address byte followed by any number of data bytes. Each data byte is written to consecutive memory addresses.

Parameters:
- M, 10, number of memory words (must match the downstream memory).
- N, 8, word width and SPI frame width in bits.
- SYNC_STAGES, 2, flip-flop synchronizer depth on sclk, mosi and cs_n.

Ports:
- clk  in  1  system clock; must be at least 4x the sclk frequency.
- rst_n  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock, asynchronous to clk.
- mosi  in  1  SPI data in, MSB first.
- cs_n  in  1  SPI chip select, active low.
- miso  out  1  echo of the previous received byte, MSB first.
- data_out  out  N  write data to memory data_in.
- addr_out  out  $clog2(M)  write address to memory addr.
- write_enable  out  1  one-clk write strobe to memory.
- busy  out  1  high while a transaction is in progress (state != IDLE).
- load_done  out  1  one-clk pulse at the end of a transaction that wrote at least one byte.
- addr_err  out  1  sticky flag: start address was >= M; cleared by reset or by a new cs_n fall.

Behaviour:
- Reset: asynchronous, active-low; one clock (clk); no other reset.
- Reset values: all outputs 0; state IDLE; synchronizers, shift registers, bit counter and address pointer all 0.
- Reset asserted mid-transaction aborts it immediately; no write is issued.
- Input conditioning:
  - sclk, mosi and cs_n each pass through a SYNC_STAGES flip-flop synchronizer.
  - sclk rise and fall are edge-detected in the clk domain (synced value vs. its one-cycle-delayed copy).
- States:
  - IDLE: wait for synced cs_n low → ADDR; clear bit_cnt and addr_err.
  - ADDR: on each sclk rise, rx <= {rx[N-2:0], mosi}; bit_cnt++. After N bits:
    - value < M: ptr <= value[AW-1:0] → DATA.
    - value >= M: addr_err <= 1 → DISCARD.
  - DATA: shift the same way. On the Nth bit, latch the assembled byte and bit_cnt <= 0. In the next clk cycle:
    - write_enable = 1 for exactly 1 cycle;
    - data_out = byte; addr_out = ptr;
    - ptr <= (ptr == M-1) ? 0 : ptr + 1 (wrap-around).
  - DISCARD: keep shifting; never write; stay until cs_n high.
- Any state, synced cs_n high → IDLE:
  - a partial byte is discarded and bit_cnt cleared;
  - load_done pulses for 1 cycle if that transaction wrote at least one byte.
- Latency: sclk rise of the Nth data bit (rise-detect cycle T) → write_enable high in cycle T+1.
- data_out and addr_out hold their last values between strobes.
- Simultaneous events: if cs_n deasserts in the same cycle a write strobe is due, the write still completes, and load_done pulses one cycle after the strobe.
- miso echo:
  - every completed byte (address or data) is loaded into tx;
  - on each synced sclk fall, miso <= tx[N-1] and tx shifts left;
  - miso is 0 in IDLE and for the first byte of each transaction.
- Throughput: back-to-back bytes with no gap are supported; the write strobe for byte k never overlaps the sampling of byte k+1.

Decomposition:
- Shared package holds:
  - localparam AW = $clog2(M);
  - the state encoding IDLE=0, ADDR=1, DATA=2, DISCARD=3.
- One sub-module is natural: sync_edge_detect.
  - Per-signal SYNC_STAGES synchronizer with rise/fall pulse outputs.
  - Instantiated three times: sclk, mosi, cs_n (edge outputs unused on mosi).

Test Plan:
- Reset mid-stream: rst_n low after 4 of 8 data bits → all outputs 0 asynchronously; no write; after release the next transaction behaves normally.
- Basic load: cs_n low, send 0x03, 0xA5, 0x5A, cs_n high →
  - write_enable pulses exactly twice: (addr 3, 0xA5) then (addr 4, 0x5A);
  - load_done pulses once; addr_err stays 0.
- Wrap-around: start 0x08, data 0x11, 0x22, 0x33 → writes at addresses 8, 9, 0 with those values.
- Bad address: start 0x0C (M=10) → addr_err = 1; no write_enable for the 2 following bytes; no load_done. The next transaction with start 0x00 clears addr_err.
- Aborted byte: start 0x01, data 0xFF, then 5 bits of a second byte, cs_n high → exactly one write (addr 1, 0xFF); load_done pulses; the next transaction starts cleanly at bit 0.
- miso echo: send 0x02, 0xC3, 0x3C → miso outputs 0x00 during byte 1, 0x02 during byte 2 and 0xC3 during byte 3 (MSB first, changing on sclk fall).
